// File: rtl/comb_y2_if.sv
// Code inputs {D,C,B,A} and the prime-detect results Y / Y_q.
// No handshake is involved: level signals only.
interface comb_y2_if;
    logic A;
    logic B;
    logic C;
    logic D;
    logic Y;
    logic Y_q;

    modport master (output A, B, C, D, input Y, Y_q);
    modport slave  (input A, B, C, D, output Y, Y_q);
endinterface

// File: rtl/comb_y2.sv
// Purpose: flags when the 4-bit code {D,C,B,A} is prime; Y_q is a registered copy.
// Latency: Y is combinational (0 cycles); Y_q follows Y one clk later.
// Backpressure: none, the block accepts a new code every cycle.
module comb_y2 (
    input  logic      clk,
    input  logic      rst_n,
    comb_y2_if.slave  bus
);

    logic w_y;
    logic r_y_q;

    // Minimised cover of minterms 2,3,5,7,11,13.
    assign w_y = (~bus.D & ~bus.C &  bus.B)
               | (~bus.D &  bus.C &  bus.A)
               | (~bus.C &  bus.B &  bus.A)
               | ( bus.C & ~bus.B &  bus.A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q <= 1'b0;
        end else begin
            r_y_q <= w_y;
        end
    end

    assign bus.Y   = w_y;
    assign bus.Y_q = r_y_q;

endmodule

// File: tb/tb_comb_y2.sv
// Bench for comb_y2: vector table, reset/latency sequences and random codes vs. a primality model.
module tb_comb_y2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    comb_y2_if bus ();

    comb_y2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [3:0] n;
        logic       y;
    } vec_t;

    vec_t vecs [21];

    function automatic logic is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_n(input logic [3:0] v);
        bus.A = v[0];
        bus.B = v[1];
        bus.C = v[2];
        bus.D = v[3];
    endtask

    initial begin
        logic [15:0] seq;
        logic [3:0]  rn;
        total = 0;
        bad   = 0;

        // Expected sweep Y sequence, bit i = Y for code i.
        seq = 16'h28AC;
        for (int i = 0; i < 16; i++) begin
            vecs[i].n = 4'(i);
            vecs[i].y = seq[i];
        end
        vecs[16] = '{4'd0,  1'b0};
        vecs[17] = '{4'd11, 1'b1};
        vecs[18] = '{4'd9,  1'b0};
        vecs[19] = '{4'd2,  1'b1};
        vecs[20] = '{4'd15, 1'b0};

        // Reset with N=7
        rst_n = 1'b0;
        set_n(4'd7);
        #5;
        chk("reset_y", bus.Y, 1'b1);
        chk("reset_yq", bus.Y_q, 1'b0);
        @(posedge clk); #1;
        chk("reset_yq_clk", bus.Y_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_yq_before_edge", bus.Y_q, 1'b0);
        @(posedge clk); #1;
        chk("release_yq_after_edge", bus.Y_q, 1'b1);

        // Table sweep plus spot checks
        foreach (vecs[i]) begin
            @(negedge clk);
            set_n(vecs[i].n);
            #1;
            chk($sformatf("vec_y[%0d]", i), bus.Y, vecs[i].y);
            chk($sformatf("vec_model[%0d]", i), bus.Y, is_prime(int'(vecs[i].n)));
            @(posedge clk); #1;
            chk($sformatf("vec_yq[%0d]", i), bus.Y_q, vecs[i].y);
        end

        // Registered latency 4 -> 5 between edges
        @(negedge clk);
        set_n(4'd4);
        @(posedge clk); #1;
        chk("lat_yq_4", bus.Y_q, 1'b0);
        @(negedge clk); #2;
        set_n(4'd5);
        #1;
        chk("lat_y_5", bus.Y, 1'b1);
        chk("lat_yq_hold", bus.Y_q, 1'b0);
        @(posedge clk); #1;
        chk("lat_yq_5", bus.Y_q, 1'b1);

        // Async reset between edges while Y_q = 1
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("areset_yq", bus.Y_q, 1'b0);
        set_n(4'd13);
        #1;
        chk("areset_y_13", bus.Y, 1'b1);
        set_n(4'd8);
        #1;
        chk("areset_y_8", bus.Y, 1'b0);
        set_n(4'd3);
        @(posedge clk); #1;
        chk("areset_yq_clk", bus.Y_q, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("areset_release_yq", bus.Y_q, 1'b1);

        // Random codes against the primality model
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rn = 4'($urandom_range(0, 15));
            set_n(rn);
            #1;
            chk("rand_y", bus.Y, is_prime(int'(rn)));
            @(posedge clk); #1;
            chk("rand_yq", bus.Y_q, is_prime(int'(rn)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
